// File: rtl/dpram_rd_streamer_pkg.sv
// Shared types and sizing for the dual-port RAM read streamer.
package dpram_rd_streamer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 4;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
endpackage

// File: rtl/dpram_rd_streamer_if.sv
// Ready/valid word stream produced by the read streamer.
interface dpram_rd_streamer_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (output out_valid, out_data, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/dpram_rd_streamer_skidbuf.sv
// Small single-clock FIFO holding returned RAM words until the consumer takes them.
module dpram_rd_streamer_skidbuf
    import dpram_rd_streamer_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;

    assign dout = mem[rd_ptr];

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/dpram_rd_streamer.sv
// Read-side master for the dual-port RAM: issues reads and streams words out with backpressure.
// Optional DPRAM_RD_ABORT_EN adds an abort input that flushes the command in progress.
module dpram_rd_streamer
    import dpram_rd_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    input  logic [DATA_WIDTH-1:0] rddata,
`ifdef DPRAM_RD_ABORT_EN
    input  logic                  abort,
`endif
    dpram_rd_streamer_if.master   strm
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam int OW = CNT_W + 1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LW-1:0]         issue_left;
    logic [2:1]            vld_pipe;
    logic [2:1]            lst_pipe;
    logic [CNT_W-1:0]      buf_cnt;
    logic [DATA_WIDTH:0]   buf_dout;
    logic                  pop;
    logic                  accept;
    logic                  can_issue;
    logic                  abort_hit;

    assign strm.out_valid = (buf_cnt != '0);
    assign strm.out_data  = buf_dout[DATA_WIDTH-1:0];
    assign strm.out_last  = strm.out_valid & buf_dout[DATA_WIDTH];
    assign pop            = strm.out_valid & strm.out_ready;
    assign busy           = (state != ST_IDLE);
    assign accept         = (state == ST_IDLE) & start & (length != '0);

`ifdef DPRAM_RD_ABORT_EN
    assign abort_hit = abort & busy;
`else
    assign abort_hit = 1'b0;
`endif

    // Buffered plus in-flight words must stay below depth; a same-cycle pop frees one slot.
    assign can_issue = (OW'(buf_cnt) + OW'(vld_pipe[1]) + OW'(vld_pipe[2]))
                       < (OW'(BUF_DEPTH) + OW'(pop));

    dpram_rd_streamer_skidbuf #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort_hit),
        .push  (vld_pipe[2]),
        .din   ({lst_pipe[2], rddata}),
        .pop   (pop),
        .dout  (buf_dout),
        .count (buf_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            issue_left <= '0;
            rdaddr     <= '0;
            vld_pipe   <= '0;
            lst_pipe   <= '0;
            done       <= 1'b0;
        end else begin
            done        <= 1'b0;
            vld_pipe[2] <= vld_pipe[1];
            lst_pipe[2] <= lst_pipe[1];
            vld_pipe[1] <= 1'b0;
            lst_pipe[1] <= 1'b0;
            if (abort_hit) begin
                state    <= ST_IDLE;
                vld_pipe <= '0;
                lst_pipe <= '0;
                done     <= 1'b1;
            end else begin
                case (state)
                    // The buffer is always empty here, so the first read issues with the start.
                    ST_IDLE: if (accept) begin
                        rdaddr      <= start_addr;
                        addr_q      <= start_addr + 1'b1;
                        issue_left  <= length - 1'b1;
                        vld_pipe[1] <= 1'b1;
                        lst_pipe[1] <= (length == LW'(1));
                        state       <= (length == LW'(1)) ? ST_DRAIN : ST_ISSUE;
                    end
                    ST_ISSUE: if (can_issue) begin
                        rdaddr      <= addr_q;
                        addr_q      <= addr_q + 1'b1;
                        issue_left  <= issue_left - 1'b1;
                        vld_pipe[1] <= 1'b1;
                        lst_pipe[1] <= (issue_left == LW'(1));
                        if (issue_left == LW'(1))
                            state <= ST_DRAIN;
                    end
                    ST_DRAIN: if (pop && strm.out_last) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
